// File: rtl/generic_io_dft_pkg.sv
`default_nettype none
// =============================================================================
// Module   : generic_io_dft_pkg
// Purpose  : Shared state encoding and default widths for the IO-DFT sequencer.
// Revision : 1.0
// =============================================================================
package generic_io_dft_pkg;

    localparam int IO_DFT_MISR_LFSR_DW_DEF = 8;
    localparam int IO_DFT_CNT_W_DEF        = 16;
    localparam int IO_DFT_LOAD_CYC_DEF     = 2;
    localparam int IO_DFT_IN_FB_DLY_DEF    = 1;

    typedef enum logic [2:0] {
        IO_DFT_SEQ_IDLE  = 3'd0,
        IO_DFT_SEQ_LOAD  = 3'd1,
        IO_DFT_SEQ_ARM   = 3'd2,
        IO_DFT_SEQ_RUN   = 3'd3,
        IO_DFT_SEQ_DRAIN = 3'd4,
        IO_DFT_SEQ_CHECK = 3'd5,
        IO_DFT_SEQ_DONE  = 3'd6
    } io_dft_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/generic_io_dft_seq_cnt.sv
`default_nettype none
// =============================================================================
// Module   : generic_io_dft_seq_cnt
// Purpose  : Loadable down-counter; tc_o flags the last counted cycle (count<=1).
// Revision : 1.0
// =============================================================================
module generic_io_dft_seq_cnt
    import generic_io_dft_pkg::*;
#(
    parameter int CNT_W = IO_DFT_CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Treating zero as terminal too keeps a stray empty count from stalling the FSM.
    assign tc_o = (cnt_q[CNT_W-1:1] == '0);

endmodule
`default_nettype wire

// File: rtl/generic_io_dft_seq.sv
`default_nettype none
// =============================================================================
// Module   : generic_io_dft_seq
// Purpose  : Timed seed-load / capture / drain / compare sequencer for the input MISR.
// Revision : 1.0
// =============================================================================
module generic_io_dft_seq
    import generic_io_dft_pkg::*;
#(
    parameter int MISR_LFSR_DW     = IO_DFT_MISR_LFSR_DW_DEF,
    parameter int CNT_W            = IO_DFT_CNT_W_DEF,
    parameter int LOAD_CYC         = IO_DFT_LOAD_CYC_DEF,
    parameter int IO_DFT_IN_FB_DLY = IO_DFT_IN_FB_DLY_DEF
) (
    input  logic                    func_clk,
    input  logic                    func_rst_n,
    input  logic                    seq_go,
    input  logic [CNT_W-1:0]        seq_run_len,
    input  logic [MISR_LFSR_DW-1:0] seq_exp_sig,
    input  logic [MISR_LFSR_DW-1:0] seq_sig_mask,
    input  logic [MISR_LFSR_DW-1:0] misr_sig,
    output logic                    dft_en,
    output logic                    dft_start,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic                    seq_pass,
    output logic [MISR_LFSR_DW-1:0] seq_sig,
    output logic [2:0]              seq_state
);

    localparam logic [CNT_W-1:0] C_LOAD_CNT  = CNT_W'(LOAD_CYC);
    localparam logic [CNT_W-1:0] C_DRAIN_CNT = CNT_W'(IO_DFT_IN_FB_DLY + 1);

    io_dft_seq_state_e         state_q, state_d;
    logic                      go_q;
    logic [CNT_W-1:0]          run_len_q, run_len_d;
    logic                      dft_en_q, dft_start_q, busy_q, done_q, pass_q;
    logic [MISR_LFSR_DW-1:0]   sig_q;

    logic                      w_start_evt;
    logic                      w_cnt_load;
    logic [CNT_W-1:0]          w_cnt_load_val;
    logic                      w_cnt_dec;
    logic                      w_cnt_tc;

    assign w_start_evt = seq_go && !go_q;

    generic_io_dft_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i      (func_clk),
        .rst_n_i    (func_rst_n),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_load_val),
        .dec_i      (w_cnt_dec),
        .tc_o       (w_cnt_tc)
    );

    // The single counter is reloaded on every timed-state entry; aborts clear it.
    always_comb begin
        state_d        = state_q;
        run_len_d      = run_len_q;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (state_q)
            IO_DFT_SEQ_IDLE: begin
                if (w_start_evt) begin
                    state_d        = IO_DFT_SEQ_LOAD;
                    run_len_d      = seq_run_len;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_LOAD_CNT;
                end
            end
            IO_DFT_SEQ_LOAD: begin
                if (!seq_go) begin
                    state_d    = IO_DFT_SEQ_IDLE;
                    w_cnt_load = 1'b1;
                end else if (w_cnt_tc) begin
                    state_d = IO_DFT_SEQ_ARM;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            IO_DFT_SEQ_ARM: begin
                w_cnt_load = 1'b1;
                if (!seq_go) begin
                    state_d = IO_DFT_SEQ_IDLE;
                end else if (run_len_q == '0) begin
                    state_d        = IO_DFT_SEQ_DRAIN;
                    w_cnt_load_val = C_DRAIN_CNT;
                end else begin
                    state_d        = IO_DFT_SEQ_RUN;
                    w_cnt_load_val = run_len_q;
                end
            end
            IO_DFT_SEQ_RUN: begin
                if (!seq_go) begin
                    state_d    = IO_DFT_SEQ_IDLE;
                    w_cnt_load = 1'b1;
                end else if (w_cnt_tc) begin
                    state_d        = IO_DFT_SEQ_DRAIN;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_DRAIN_CNT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            IO_DFT_SEQ_DRAIN: begin
                if (!seq_go) begin
                    state_d    = IO_DFT_SEQ_IDLE;
                    w_cnt_load = 1'b1;
                end else if (w_cnt_tc) begin
                    state_d = IO_DFT_SEQ_CHECK;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            IO_DFT_SEQ_CHECK: begin
                state_d = IO_DFT_SEQ_DONE;
            end
            IO_DFT_SEQ_DONE: begin
                if (!seq_go) begin
                    state_d = IO_DFT_SEQ_IDLE;
                end
            end
            default: begin
                state_d    = IO_DFT_SEQ_IDLE;
                w_cnt_load = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge func_clk) begin
        if (!func_rst_n) begin
            state_q     <= IO_DFT_SEQ_IDLE;
            go_q        <= 1'b0;
            run_len_q   <= '0;
            dft_en_q    <= 1'b0;
            dft_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            go_q        <= seq_go;
            run_len_q   <= run_len_d;
            dft_en_q    <= (state_d != IO_DFT_SEQ_IDLE) && (state_d != IO_DFT_SEQ_LOAD);
            dft_start_q <= (state_d == IO_DFT_SEQ_RUN);
            busy_q      <= (state_d == IO_DFT_SEQ_LOAD)  || (state_d == IO_DFT_SEQ_ARM) ||
                           (state_d == IO_DFT_SEQ_RUN)   || (state_d == IO_DFT_SEQ_DRAIN) ||
                           (state_d == IO_DFT_SEQ_CHECK);
            done_q      <= (state_d == IO_DFT_SEQ_DONE);
            if (state_q == IO_DFT_SEQ_CHECK) begin
                sig_q  <= misr_sig;
                pass_q <= ~|((misr_sig ^ seq_exp_sig) & seq_sig_mask);
            end else if (state_d != IO_DFT_SEQ_DONE) begin
                pass_q <= 1'b0;
            end
        end
    end

    assign dft_en    = dft_en_q;
    assign dft_start = dft_start_q;
    assign seq_busy  = busy_q;
    assign seq_done  = done_q;
    assign seq_pass  = pass_q;
    assign seq_sig   = sig_q;
    assign seq_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_generic_io_dft_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_generic_io_dft_seq
// Purpose  : Self-checking bench for generic_io_dft_seq (default build + FB_DLY=3 build).
// Revision : 1.0
// =============================================================================
module tb_generic_io_dft_seq;

    localparam int LC  = 2;
    localparam int FB  = 1;
    localparam int FB2 = 3;

    logic        func_clk    = 1'b0;
    logic        func_rst_n  = 1'b0;
    logic        seq_go      = 1'b0;
    logic [15:0] seq_run_len = '0;
    logic [7:0]  seq_exp_sig = '0;
    logic [7:0]  seq_sig_mask = '0;
    logic [7:0]  misr_sig    = '0;

    logic       dft_en, dft_start, seq_busy, seq_done, seq_pass;
    logic [7:0] seq_sig;
    logic [2:0] seq_state;
    logic       b_en, b_start, b_busy, b_done, b_pass;
    logic [7:0] b_sig;
    logic [2:0] b_state;

    int checks = 0;
    int errors = 0;

    generic_io_dft_seq #(
        .MISR_LFSR_DW(8), .CNT_W(16), .LOAD_CYC(LC), .IO_DFT_IN_FB_DLY(FB)
    ) dut (
        .func_clk(func_clk), .func_rst_n(func_rst_n), .seq_go(seq_go),
        .seq_run_len(seq_run_len), .seq_exp_sig(seq_exp_sig), .seq_sig_mask(seq_sig_mask),
        .misr_sig(misr_sig), .dft_en(dft_en), .dft_start(dft_start), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_pass(seq_pass), .seq_sig(seq_sig), .seq_state(seq_state)
    );

    generic_io_dft_seq #(
        .MISR_LFSR_DW(8), .CNT_W(16), .LOAD_CYC(LC), .IO_DFT_IN_FB_DLY(FB2)
    ) dut_fb3 (
        .func_clk(func_clk), .func_rst_n(func_rst_n), .seq_go(seq_go),
        .seq_run_len(seq_run_len), .seq_exp_sig(seq_exp_sig), .seq_sig_mask(seq_sig_mask),
        .misr_sig(misr_sig), .dft_en(b_en), .dft_start(b_start), .seq_busy(b_busy),
        .seq_done(b_done), .seq_pass(b_pass), .seq_sig(b_sig), .seq_state(b_state)
    );

    always #5 func_clk = ~func_clk;

    task automatic tick();
        @(posedge func_clk);
        #1;
    endtask

    // One full session: go rises, cycle k counts edges after the rise.
    task automatic run_session(input int rl, input logic [7:0] m, input logic [7:0] e,
                               input logic [7:0] msk, input int hold, input bit chk2);
        int lat, lat2, starts, drain2, done2_at;
        logic [3:0] exp_v, got_v;
        logic exp_pass;
        lat      = LC + 1 + rl + (FB + 1) + 1 + 1;
        lat2     = LC + 1 + rl + (FB2 + 1) + 1 + 1;
        exp_pass = (((m ^ e) & msk) == 8'h00);
        starts = 0; drain2 = 0; done2_at = 0;
        seq_run_len  = rl[15:0];
        misr_sig     = m;
        seq_exp_sig  = e;
        seq_sig_mask = msk;
        seq_go       = 1'b1;
        for (int k = 1; k <= lat + hold; k++) begin
            tick();
            if (k == 1) begin
                seq_run_len  = 16'($urandom);
                seq_exp_sig  = 8'($urandom);
                seq_sig_mask = 8'($urandom);
            end
            if (k == 2) begin
                seq_exp_sig  = e;
                seq_sig_mask = msk;
            end
            if (b_state == 3'd4) drain2++;
            if (b_done && done2_at == 0) done2_at = k;
            if (k <= lat) begin
                exp_v = {k > LC, (k > LC + 1) && (k <= LC + 1 + rl), k < lat, k == lat};
                got_v = {dft_en, dft_start, seq_busy, seq_done};
                starts += int'(dft_start);
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL wave rl=%0d cyc=%0d {en,start,busy,done} got=%b exp=%b", rl, k, got_v, exp_v);
                end
            end else begin
                checks++;
                if ({seq_state, seq_done, seq_pass} !== {3'd6, 1'b1, exp_pass}) begin
                    errors++;
                    $display("FAIL done_hold cyc=%0d {state,done,pass} got=%b exp=%b", k,
                             {seq_state, seq_done, seq_pass}, {3'd6, 1'b1, exp_pass});
                end
            end
        end
        checks++;
        if (starts != rl) begin
            errors++;
            $display("FAIL start_len got=%0d exp=%0d", starts, rl);
        end
        checks++;
        if ({seq_pass, seq_sig} !== {exp_pass, m}) begin
            errors++;
            $display("FAIL result {pass,sig} got=%b/%h exp=%b/%h", seq_pass, seq_sig, exp_pass, m);
        end
        if (chk2) begin
            checks++;
            if (drain2 != FB2 + 1) begin
                errors++;
                $display("FAIL fb3_drain_len got=%0d exp=%0d", drain2, FB2 + 1);
            end
            checks++;
            if (done2_at != lat2) begin
                errors++;
                $display("FAIL fb3_latency got=%0d exp=%0d", done2_at, lat2);
            end
        end
        seq_go = 1'b0;
        tick();
        checks++;
        if ({seq_state, seq_done, seq_pass, seq_busy, dft_en, dft_start} !== 8'h00) begin
            errors++;
            $display("FAIL exit_idle got=%b exp=%b",
                     {seq_state, seq_done, seq_pass, seq_busy, dft_en, dft_start}, 8'h00);
        end
        checks++;
        if (seq_sig !== m) begin
            errors++;
            $display("FAIL sig_retained got=%h exp=%h", seq_sig, m);
        end
    endtask

    task automatic test_reset();
        func_rst_n = 1'b0;
        seq_go     = 1'b1;
        tick();
        tick();
        checks++;
        if ({dft_en, dft_start, seq_busy, seq_done, seq_pass, seq_sig, seq_state} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0000",
                     {dft_en, dft_start, seq_busy, seq_done, seq_pass, seq_sig, seq_state});
        end
        func_rst_n = 1'b1;
        seq_go     = 1'b0;
        tick();
        checks++;
        if ({seq_state, dft_en} !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", {seq_state, dft_en});
        end
    endtask

    task automatic test_directed();
        run_session(4, 8'hA5, 8'hA5, 8'hFF, 3, 1'b1);
        run_session(4, 8'hA4, 8'hA5, 8'hFF, 0, 1'b0);
        run_session(4, 8'hA4, 8'hA5, 8'hFE, 1, 1'b0);
        run_session(0, 8'h5A, 8'h5A, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] m, e;
        for (int i = 0; i < 8; i++) begin
            m = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? m : 8'($urandom);
            run_session($urandom_range(0, 20), m, e, 8'($urandom), $urandom_range(0, 3), 1'b0);
        end
        run_session(3, 8'h10, 8'h00, 8'hFF, 4, 1'b1);
    endtask

    task automatic test_abort();
        logic saw_done;
        seq_run_len = 16'd10;
        misr_sig    = 8'h77;
        seq_go      = 1'b1;
        for (int k = 1; k <= LC + 3; k++) tick();
        checks++;
        if ({seq_state, dft_start} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL abort_in_run got=%b exp=%b", {seq_state, dft_start}, {3'd3, 1'b1});
        end
        seq_go = 1'b0;
        tick();
        checks++;
        if ({seq_state, dft_en, dft_start, seq_busy, seq_done} !== 7'h00) begin
            errors++;
            $display("FAIL abort_idle got=%b exp=0", {seq_state, dft_en, dft_start, seq_busy, seq_done});
        end
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            saw_done |= seq_done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got=%b exp=0", saw_done);
        end
        run_session(5, 8'h3C, 8'h3C, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        seq_run_len = 16'd3;
        misr_sig    = 8'h99;
        seq_go      = 1'b1;
        for (int k = 1; k <= LC + 1 + 3 + 1; k++) tick();
        checks++;
        if (seq_state !== 3'd4) begin
            errors++;
            $display("FAIL reset_mid_drain got=%0d exp=4", seq_state);
        end
        func_rst_n = 1'b0;
        seq_go     = 1'b0;
        tick();
        func_rst_n = 1'b1;
        checks++;
        if ({dft_en, dft_start, seq_busy, seq_done, seq_pass, seq_sig, seq_state} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h exp=0000",
                     {dft_en, dft_start, seq_busy, seq_done, seq_pass, seq_sig, seq_state});
        end
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            saw_done |= seq_done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got=%b exp=0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        run_session(3, 8'hC3, 8'hC3, 8'hF0, 4, 1'b0);
        run_session(6, 8'h81, 8'h01, 8'h7F, 0, 1'b0);
        run_session(1, 8'hFF, 8'h00, 8'h00, 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
